// File: rtl/id_stage_pipe_if.sv
// Fetch-to-decode and decode-to-EX signal bundle of the ID stage.
// The slave modport is the stage itself; the master modport is its environment.
interface id_stage_pipe_if #(
  parameter int XLEN = 64
);
  logic            flush_i;
  logic            if_valid_i;
  logic            id_ready_o;
  logic [XLEN-1:0] if_pc_i;
  logic [31:0]     if_instr_i;
  logic [4:0]      id_rs1_idx_o;
  logic [4:0]      id_rs2_idx_o;
  logic [XLEN-1:0] rf_rs1_rdata_i;
  logic [XLEN-1:0] rf_rs2_rdata_i;
  logic            id_valid_o;
  logic            ex_ready_i;
  logic [XLEN-1:0] id_pc_o;
  logic [11:0]     id_opcode_info_o;
  logic [17:0]     id_alu_info_o;
  logic [5:0]      id_branch_info_o;
  logic [10:0]     id_ld_st_info_o;
  logic [5:0]      id_csr_info_o;
  logic [11:0]     id_csr_idx_o;
  logic [XLEN-1:0] id_rs1_rdata_o;
  logic [XLEN-1:0] id_rs2_rdata_o;
  logic [XLEN-1:0] id_imm_o;
  logic            id_rd_wen_o;
  logic [4:0]      id_rd_idx_o;
  logic [3:0]      id_excp_o;

  modport master (
    output flush_i, if_valid_i, if_pc_i, if_instr_i, rf_rs1_rdata_i, rf_rs2_rdata_i, ex_ready_i,
    input  id_ready_o, id_rs1_idx_o, id_rs2_idx_o, id_valid_o, id_pc_o, id_opcode_info_o,
           id_alu_info_o, id_branch_info_o, id_ld_st_info_o, id_csr_info_o, id_csr_idx_o,
           id_rs1_rdata_o, id_rs2_rdata_o, id_imm_o, id_rd_wen_o, id_rd_idx_o, id_excp_o
  );

  modport slave (
    input  flush_i, if_valid_i, if_pc_i, if_instr_i, rf_rs1_rdata_i, rf_rs2_rdata_i, ex_ready_i,
    output id_ready_o, id_rs1_idx_o, id_rs2_idx_o, id_valid_o, id_pc_o, id_opcode_info_o,
           id_alu_info_o, id_branch_info_o, id_ld_st_info_o, id_csr_info_o, id_csr_idx_o,
           id_rs1_rdata_o, id_rs2_rdata_o, id_imm_o, id_rd_wen_o, id_rd_idx_o, id_excp_o
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: RV32I/RV64I (+M) decode into a two-entry skid buffer,
// so the upstream ready is a plain flop and never looks at ex_ready_i.
module id_stage_pipe #(
  parameter int XLEN  = 64,
  parameter int M_EXT = 1
) (
  input logic            clk,
  input logic            rst_n,
  id_stage_pipe_if.slave bus
);
  localparam bit RV64  = (XLEN == 64);
  localparam bit HAS_M = (M_EXT != 0);
  localparam logic [9:0] SUB = 10'b01_0000_0000;
  localparam logic [9:0] SRA = 10'b00_0000_0100;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [11:0]     opcode;
    logic [17:0]     alu;
    logic [5:0]      branch;
    logic [10:0]     ldSt;
    logic [5:0]      csr;
    logic [11:0]     csrIdx;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            rdWen;
    logic [4:0]      rdIdx;
    logic [3:0]      excp;
  } bundle_t;

  // funct3 to {add,sub,sll,slt,sltu,xor,srl,sra,or,and} for funct7 = 0
  function automatic logic [9:0] baseOp(input logic [2:0] f);
    case (f)
      3'b000:  baseOp = 10'b10_0000_0000;
      3'b001:  baseOp = 10'b00_1000_0000;
      3'b010:  baseOp = 10'b00_0100_0000;
      3'b011:  baseOp = 10'b00_0010_0000;
      3'b100:  baseOp = 10'b00_0001_0000;
      3'b101:  baseOp = 10'b00_0000_1000;
      3'b110:  baseOp = 10'b00_0000_0010;
      default: baseOp = 10'b00_0000_0001;
    endcase
  endfunction

  logic [31:0] instr, immI, immS, immB, immJ, immU, imm32;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        illegal, wen;
  bundle_t     decoded;

  assign instr = bus.if_instr_i;
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign immI  = {{20{instr[31]}}, instr[31:20]};
  assign immS  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immJ  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign immU  = {instr[31:12], 12'b0};

  assign bus.id_rs1_idx_o = instr[19:15];
  assign bus.id_rs2_idx_o = instr[24:20];

  always_comb begin
    decoded = '0;
    imm32   = '0;
    illegal = 1'b0;
    wen     = 1'b1;
    case (instr[6:0])
      7'b0010011: begin
        decoded.opcode[11] = 1'b1;
        imm32 = immI;
        decoded.alu[17:8] = baseOp(f3);
        if (f3 == 3'b001) begin
          illegal = (instr[31:26] != 6'd0) || (!RV64 && instr[25]);
        end else if (f3 == 3'b101) begin
          if (instr[31:26] == 6'b010000) decoded.alu[17:8] = SRA;
          illegal = ((instr[31:26] != 6'd0) && (instr[31:26] != 6'b010000)) || (!RV64 && instr[25]);
        end
      end
      7'b0011011: begin
        decoded.opcode[10] = 1'b1;
        imm32 = immI;
        decoded.alu[17:8] = baseOp(f3);
        case (f3)
          3'b000: illegal = !RV64;
          3'b001: illegal = !RV64 || (f7 != 7'd0);
          3'b101: begin
            if (f7 == 7'b0100000) decoded.alu[17:8] = SRA;
            illegal = !RV64 || ((f7 != 7'd0) && (f7 != 7'b0100000));
          end
          default: illegal = 1'b1;
        endcase
      end
      7'b0110011, 7'b0111011: begin
        // instr[3] distinguishes the 32-bit *W register forms
        decoded.opcode[9] = ~instr[3];
        decoded.opcode[8] = instr[3];
        if (f7 == 7'b0000001) begin
          decoded.alu[{2'b00, 3'd7 - f3}] = 1'b1;
          illegal = !HAS_M || (instr[3] && (f3 inside {3'b001, 3'b010, 3'b011}));
        end else if (f7 == 7'd0) begin
          decoded.alu[17:8] = baseOp(f3);
          illegal = instr[3] && !(f3 inside {3'b000, 3'b001, 3'b101});
        end else if (f7 == 7'b0100000) begin
          decoded.alu[17:8] = (f3 == 3'b000) ? SUB : SRA;
          illegal = !(f3 inside {3'b000, 3'b101});
        end else begin
          illegal = 1'b1;
        end
        if (instr[3] && !RV64) illegal = 1'b1;
      end
      7'b1100011: begin
        decoded.opcode[7] = 1'b1;
        imm32 = immB;
        wen   = 1'b0;
        case (f3)
          3'b000:  decoded.branch = 6'b100000;
          3'b001:  decoded.branch = 6'b010000;
          3'b100:  decoded.branch = 6'b001000;
          3'b101:  decoded.branch = 6'b000100;
          3'b110:  decoded.branch = 6'b000010;
          3'b111:  decoded.branch = 6'b000001;
          default: illegal = 1'b1;
        endcase
      end
      7'b1101111: begin
        decoded.opcode[6] = 1'b1;
        imm32 = immJ;
      end
      7'b1100111: begin
        decoded.opcode[5] = 1'b1;
        imm32   = immI;
        illegal = (f3 != 3'b000);
      end
      7'b0000011: begin
        decoded.opcode[4] = 1'b1;
        imm32 = immI;
        decoded.ldSt[4'd10 - {1'b0, f3}] = 1'b1;
        illegal = (f3 == 3'b111) || (!RV64 && (f3 inside {3'b011, 3'b110}));
      end
      7'b0100011: begin
        decoded.opcode[3] = 1'b1;
        imm32 = immS;
        wen   = 1'b0;
        decoded.ldSt[{2'b00, 2'd3 - f3[1:0]}] = 1'b1;
        illegal = f3[2] || (!RV64 && (f3 == 3'b011));
      end
      7'b0110111: begin
        decoded.opcode[2] = 1'b1;
        imm32 = immU;
      end
      7'b0010111: begin
        decoded.opcode[1] = 1'b1;
        imm32 = immU;
      end
      7'b1110011: begin
        decoded.opcode[0] = 1'b1;
        case (f3)
          3'b000: begin
            wen = 1'b0;
            decoded.excp[2] = (instr == 32'h0000_0073);
            decoded.excp[1] = (instr == 32'h0010_0073);
            decoded.excp[0] = (instr == 32'h3020_0073);
            illegal = (decoded.excp[2:0] == 3'b000);
          end
          3'b001:  decoded.csr = 6'b100000;
          3'b010:  decoded.csr = 6'b010000;
          3'b011:  decoded.csr = 6'b001000;
          3'b101:  decoded.csr = 6'b000100;
          3'b110:  decoded.csr = 6'b000010;
          3'b111:  decoded.csr = 6'b000001;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      decoded.opcode = '0;
      decoded.alu    = '0;
      decoded.branch = '0;
      decoded.ldSt   = '0;
      decoded.csr    = '0;
      decoded.excp   = 4'b1000;
      imm32          = '0;
      wen            = 1'b0;
    end
    decoded.pc     = bus.if_pc_i;
    decoded.rs1    = bus.rf_rs1_rdata_i;
    decoded.rs2    = bus.rf_rs2_rdata_i;
    decoded.csrIdx = instr[31:20];
    decoded.rdIdx  = instr[11:7];
    decoded.imm    = XLEN'($signed(imm32));
    decoded.rdWen  = wen;
  end

  state_e  state_q, state_d;
  logic    ready_q;
  bundle_t out_q, skd_q;
  logic    accept, fire, loadOut, loadSkd, skdToOut;

  assign accept = bus.if_valid_i & ready_q;
  assign fire   = (state_q != EMPTY) & bus.ex_ready_i;

  always_comb begin
    state_d  = state_q;
    loadOut  = 1'b0;
    loadSkd  = 1'b0;
    skdToOut = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        loadOut = 1'b1;
        state_d = ONE;
      end
      ONE: begin
        if (accept && fire) begin
          loadOut = 1'b1;
        end else if (accept) begin
          loadSkd = 1'b1;
          state_d = FULL;
        end else if (fire) begin
          state_d = EMPTY;
        end
      end
      FULL: if (fire) begin
        skdToOut = 1'b1;
        state_d  = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // a flush drops everything buffered plus the beat on the input this cycle
    if (bus.flush_i) begin
      state_d  = EMPTY;
      loadOut  = 1'b0;
      loadSkd  = 1'b0;
      skdToOut = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
      skd_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      if (loadOut) out_q <= decoded;
      else if (skdToOut) out_q <= skd_q;
      if (loadSkd) skd_q <= decoded;
    end
  end

  assign bus.id_ready_o       = ready_q;
  assign bus.id_valid_o       = (state_q != EMPTY);
  assign bus.id_pc_o          = out_q.pc;
  assign bus.id_opcode_info_o = out_q.opcode;
  assign bus.id_alu_info_o    = out_q.alu;
  assign bus.id_branch_info_o = out_q.branch;
  assign bus.id_ld_st_info_o  = out_q.ldSt;
  assign bus.id_csr_info_o    = out_q.csr;
  assign bus.id_csr_idx_o     = out_q.csrIdx;
  assign bus.id_rs1_rdata_o   = out_q.rs1;
  assign bus.id_rs2_rdata_o   = out_q.rs2;
  assign bus.id_imm_o         = out_q.imm;
  assign bus.id_rd_wen_o      = out_q.rdWen;
  assign bus.id_rd_idx_o      = out_q.rdIdx;
  assign bus.id_excp_o        = out_q.excp;
endmodule
